// File: rtl/rv_pkg.sv
// Shared core definitions for the register-file write path.
//   XLEN        datapath width
//   REG_ADDR_W  register index width
//   arb_state_e write-port arbiter states
//   wb_entry_t  {rd, data} pair carried through the MDU result queue
package rv_pkg;
  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int WB_ENTRY_W = REG_ADDR_W + XLEN;

  typedef enum logic {ARB_NORMAL, ARB_FORCE} arb_state_e;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_entry_t;
endpackage

// File: rtl/wb_result_fifo.sv
// Small synchronous FIFO holding MDU results awaiting the register-file port.
//   clk, rst_n     clock, async active-low reset (empties the queue)
//   push_valid_i   producer offers push_data_i
//   push_ready_o   queue has room (count != DEPTH)
//   push_data_i    {rd, data} entry
//   pop_i          consume head_o this cycle (ignored when empty)
//   empty_o        no entry held
//   head_o         oldest entry (registered storage, no fall-through)
module wb_result_fifo
  import rv_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push_valid_i,
  output logic                  push_ready_o,
  input  logic [WB_ENTRY_W-1:0] push_data_i,
  input  logic                  pop_i,
  output logic                  empty_o,
  output logic [WB_ENTRY_W-1:0] head_o
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WB_ENTRY_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]         count_q;
  logic                  do_push, do_pop;

  assign push_ready_o = (count_q != CW'(DEPTH));
  assign empty_o      = (count_q == '0);
  assign head_o       = mem_q[rd_ptr_q];
  assign do_push      = push_valid_i && push_ready_o;
  assign do_pop       = pop_i && !empty_o;

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset: entries are only visible through count_q.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end
endmodule

// File: rtl/rf_write_arbiter.sv
// Sole owner of the register-file write port.
// Merges writeback results with queued MDU results; a queue head denied
// MAX_WAIT cycles forces a one-cycle pipeline stall (FORCE) in which the head
// is written. Tracks destinations with MDU results outstanding for decode.
//   clk, rst_n                         clock, async active-low reset
//   pipe_wb_valid/_rd/_data            writeback-stage result
//   pipe_stall                         hold writeback and earlier stages
//   mdu_req_valid/_ready/_rd/_data     MDU result handshake
//   issue_valid, issue_rd              MDU dispatch (sets pending bit)
//   rs1/rs2/rd_addr -> *_busy          pending-bit lookups
//   rf_we, rf_waddr, rf_wdata          registered register-file write
module rf_write_arbiter
  import rv_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  parameter int MAX_WAIT   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pipe_wb_valid,
  input  logic [4:0]  pipe_wb_rd,
  input  logic [31:0] pipe_wb_data,
  output logic        pipe_stall,
  input  logic        mdu_req_valid,
  output logic        mdu_req_ready,
  input  logic [4:0]  mdu_req_rd,
  input  logic [31:0] mdu_req_data,
  input  logic        issue_valid,
  input  logic [4:0]  issue_rd,
  input  logic [4:0]  rs1_addr,
  input  logic [4:0]  rs2_addr,
  input  logic [4:0]  rd_addr,
  output logic        rs1_busy,
  output logic        rs2_busy,
  output logic        rd_busy,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata
);
  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0] MAX_WAIT_W = WW'(MAX_WAIT);

  arb_state_e state_q, state_d;
  logic [WW-1:0]   wait_q, wait_d;
  logic [31:0]     pending_q, pending_d;
  logic            rf_we_q;
  logic [4:0]      rf_waddr_q;
  logic [31:0]     rf_wdata_q;

  wb_entry_t       mdu_entry, head;
  logic            fifo_empty;
  logic            grant_pipe, grant_head, grant_any;
  logic [4:0]      grant_rd;
  logic [31:0]     grant_data;

  assign mdu_entry = '{rd: mdu_req_rd, data: mdu_req_data};

  wb_result_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .push_valid_i (mdu_req_valid),
    .push_ready_o (mdu_req_ready),
    .push_data_i  (mdu_entry),
    .pop_i        (grant_head),
    .empty_o      (fifo_empty),
    .head_o       (head)
  );

  // Arbitration and starvation tracking.
  always_comb begin
    grant_pipe = 1'b0;
    grant_head = 1'b0;
    state_d    = state_q;
    wait_d     = '0;
    case (state_q)
      ARB_NORMAL: begin
        if (pipe_wb_valid)    grant_pipe = 1'b1;
        else if (!fifo_empty) grant_head = 1'b1;
        if (!fifo_empty && !grant_head) wait_d = wait_q + WW'(1);
        if (wait_d == MAX_WAIT_W) state_d = ARB_FORCE;
      end
      ARB_FORCE: begin
        // Pipeline is held; its result is taken the following cycle.
        grant_head = !fifo_empty;
        state_d    = ARB_NORMAL;
      end
      default: state_d = ARB_NORMAL;
    endcase
  end

  assign grant_any  = grant_pipe || grant_head;
  assign grant_rd   = grant_head ? head.rd   : pipe_wb_rd;
  assign grant_data = grant_head ? head.data : pipe_wb_data;

  // Issue after the clear so a same-cycle re-issue keeps the bit set.
  always_comb begin
    pending_d = pending_q;
    if (grant_head) pending_d[head.rd] = 1'b0;
    if (issue_valid && issue_rd != 5'd0) pending_d[issue_rd] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB_NORMAL;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q  <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      pending_q <= pending_d;
      rf_we_q   <= grant_any && (grant_rd != 5'd0);
      if (grant_any) begin
        rf_waddr_q <= grant_rd;
        rf_wdata_q <= grant_data;
      end
    end
  end

  assign pipe_stall = (state_q == ARB_FORCE);
  assign rs1_busy   = pending_q[rs1_addr];
  assign rs2_busy   = pending_q[rs2_addr];
  assign rd_busy    = pending_q[rd_addr];
  assign rf_we      = rf_we_q;
  assign rf_waddr   = rf_waddr_q;
  assign rf_wdata   = rf_wdata_q;
endmodule

// File: tb/tb_rf_write_arbiter.sv
module tb_rf_write_arbiter;
  logic        clk, rst_n;
  logic        pipe_wb_valid;
  logic [4:0]  pipe_wb_rd;
  logic [31:0] pipe_wb_data;
  logic        pipe_stall;
  logic        mdu_req_valid, mdu_req_ready;
  logic [4:0]  mdu_req_rd;
  logic [31:0] mdu_req_data;
  logic        issue_valid;
  logic [4:0]  issue_rd, rs1_addr, rs2_addr, rd_addr;
  logic        rs1_busy, rs2_busy, rd_busy;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  rf_write_arbiter #(.FIFO_DEPTH(2), .MAX_WAIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .pipe_wb_valid(pipe_wb_valid), .pipe_wb_rd(pipe_wb_rd), .pipe_wb_data(pipe_wb_data),
    .pipe_stall(pipe_stall),
    .mdu_req_valid(mdu_req_valid), .mdu_req_ready(mdu_req_ready),
    .mdu_req_rd(mdu_req_rd), .mdu_req_data(mdu_req_data),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .rd_busy(rd_busy),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [4:0] rd; logic [31:0] data; } exp_t;
  exp_t exp_q[$];
  int   n_chk = 0, n_pass = 0, we_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push_exp(input logic [4:0] rd, input logic [31:0] data);
    exp_t e;
    e.rd = rd; e.data = data;
    exp_q.push_back(e);
  endtask

  // Scoreboard: every observed write must match the oldest expected one.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && rf_we) begin
      we_cnt++;
      if (exp_q.size() == 0) chk("unexpected_we", 32'(rf_waddr), 32'h0);
      else begin
        e = exp_q.pop_front();
        chk("waddr", 32'(rf_waddr), 32'(e.rd));
        chk("wdata", rf_wdata, e.data);
      end
    end
  end

  int rdy_e [7] = '{1, 1, 0, 0, 0, 0, 1};
  logic [4:0]  offer_rd [3] = '{5'd12, 5'd13, 5'd14};
  logic [31:0] offer_dt [3] = '{32'hC, 32'hD, 32'hE};

  initial begin
    logic [31:0] d;
    logic        st, acc;
    int          oi;

    rst_n = 1'b0;
    pipe_wb_valid = 0; pipe_wb_rd = 0; pipe_wb_data = 0;
    mdu_req_valid = 0; mdu_req_rd = 0; mdu_req_data = 0;
    issue_valid = 0; issue_rd = 0; rs1_addr = 0; rs2_addr = 0; rd_addr = 0;
    #12;
    chk("rst_we", 32'(rf_we), 0);
    chk("rst_waddr", 32'(rf_waddr), 0);
    chk("rst_wdata", rf_wdata, 0);
    chk("rst_stall", 32'(pipe_stall), 0);
    chk("rst_ready", 32'(mdu_req_ready), 1);
    chk("rst_busy", 32'({rs1_busy, rs2_busy, rd_busy}), 0);
    tick(); rst_n = 1'b1; tick();

    // Pipeline only.
    pipe_wb_valid = 1; pipe_wb_rd = 5; pipe_wb_data = 32'hDEADBEEF;
    push_exp(5, 32'hDEADBEEF);
    tick(); pipe_wb_valid = 0;
    chk("pipe_we", 32'(rf_we), 1);
    pipe_wb_valid = 1; pipe_wb_rd = 0; pipe_wb_data = 32'h55;
    tick(); pipe_wb_valid = 0;
    chk("pipe_rd0_we", 32'(rf_we), 0);
    tick();

    // Single MDU result to an idle pipeline.
    issue_valid = 1; issue_rd = 7; rs1_addr = 7;
    tick(); issue_valid = 0;
    chk("busy_after_issue", 32'(rs1_busy), 1);
    mdu_req_valid = 1; mdu_req_rd = 7; mdu_req_data = 32'h12;
    chk("mdu_ready", 32'(mdu_req_ready), 1);
    push_exp(7, 32'h12);
    tick(); mdu_req_valid = 0;
    chk("mdu_we_early", 32'(rf_we), 0);
    chk("busy_at_grant", 32'(rs1_busy), 1);
    tick();
    chk("mdu_we", 32'(rf_we), 1);
    chk("busy_cleared", 32'(rs1_busy), 0);
    tick();

    // Starvation: head rd=9 vs a continuously valid pipeline.
    pipe_wb_valid = 1; pipe_wb_rd = 10; d = 32'h100;
    mdu_req_valid = 1; mdu_req_rd = 9; mdu_req_data = 32'h99;
    for (int cyc = 0; cyc < 8; cyc++) begin
      pipe_wb_data = d;
      chk("starve_stall", 32'(pipe_stall), 32'(cyc == 5));
      st = pipe_stall;
      if (st) push_exp(9, 32'h99); else push_exp(10, d);
      tick();
      mdu_req_valid = 0;
      if (!st) d = d + 1;
    end
    pipe_wb_valid = 0;
    tick(); tick();

    // Full queue with the pipeline busy.
    pipe_wb_valid = 1; pipe_wb_rd = 11; d = 32'h200; oi = 0;
    for (int cyc = 0; cyc < 7; cyc++) begin
      pipe_wb_data  = d;
      mdu_req_valid = (oi < 3);
      if (oi < 3) begin mdu_req_rd = offer_rd[oi]; mdu_req_data = offer_dt[oi]; end
      chk("full_ready", 32'(mdu_req_ready), 32'(rdy_e[cyc]));
      chk("full_stall", 32'(pipe_stall), 32'(cyc == 5));
      st  = pipe_stall;
      acc = mdu_req_valid && mdu_req_ready;
      if (st) push_exp(12, 32'hC); else push_exp(11, d);
      tick();
      if (acc) oi++;
      if (!st) d = d + 1;
    end
    chk("full_all_accepted", 32'(oi), 3);
    pipe_wb_valid = 0; mdu_req_valid = 0;
    push_exp(13, 32'hD);
    push_exp(14, 32'hE);
    repeat (4) tick();

    // Same-cycle re-issue and grant of rd=3.
    issue_valid = 1; issue_rd = 3; rd_addr = 3;
    tick(); issue_valid = 0;
    mdu_req_valid = 1; mdu_req_rd = 3; mdu_req_data = 32'h33;
    push_exp(3, 32'h33);
    tick(); mdu_req_valid = 0;
    issue_valid = 1; issue_rd = 3;
    chk("rd3_busy_pre", 32'(rd_busy), 1);
    tick(); issue_valid = 0;
    chk("rd3_set_wins", 32'(rd_busy), 1);
    chk("rd3_we", 32'(rf_we), 1);
    tick();

    // Reset while stalled with two entries queued.
    pipe_wb_valid = 1; pipe_wb_rd = 15; d = 32'h300; rs1_addr = 20;
    issue_valid = 1; issue_rd = 20;
    for (int cyc = 0; cyc < 5; cyc++) begin
      pipe_wb_data  = d;
      mdu_req_valid = (cyc < 2);
      mdu_req_rd    = (cyc == 0) ? 5'd20 : 5'd21;
      mdu_req_data  = 32'h400 + 32'(cyc);
      push_exp(15, d);
      tick();
      issue_valid = 0;
      d = d + 1;
    end
    mdu_req_valid = 0;
    chk("prerst_stall", 32'(pipe_stall), 1);
    chk("prerst_busy", 32'(rs1_busy), 1);
    chk("prerst_full", 32'(mdu_req_ready), 0);
    rst_n = 1'b0;
    #1;
    chk("midrst_stall", 32'(pipe_stall), 0);
    chk("midrst_ready", 32'(mdu_req_ready), 1);
    chk("midrst_we", 32'(rf_we), 0);
    chk("midrst_waddr", 32'(rf_waddr), 0);
    chk("midrst_wdata", rf_wdata, 0);
    chk("midrst_busy", 32'(rs1_busy), 0);
    exp_q.delete();
    pipe_wb_valid = 0;
    tick(); tick();
    rst_n = 1'b1;
    we_cnt = 0;
    repeat (10) tick();
    chk("no_we_after_rst", 32'(we_cnt), 0);
    chk("post_rst_busy", 32'(rs1_busy), 0);

    chk("exp_drain", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
